systolic_ctrl: RTL



---
 rtl/systolic_pkg.sv | 30 +++
 rtl/systolic_ctrl_skew_gen.sv | 20 ++
 rtl/systolic_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared state encoding, default geometry and one-hot helper for the
// systolic array sequencer.
package systolic_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ROW   = 4;
  localparam int DEF_COL   = 4;
  localparam int MAX_LANES = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_N = 3'd2,
    ARM    = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5,
    FIN    = 3'd6
  } state_t;

  // Bit idx set when idx < n; callers truncate to their lane count.
  function automatic logic [MAX_LANES-1:0] onehot(input int idx, input int n);
    logic [MAX_LANES-1:0] v;
    v = {MAX_LANES{1'b0}};
    for (int i = 0; i < MAX_LANES; i++) begin
      v[i] = (i == idx) && (i < n);
    end
    return v;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_gen.sv
// Read-enable wavefront: lane i is open for LEN consecutive steps beginning
// at step i, giving the diagonal skew the systolic array expects.
module skew_gen #(
  parameter int N   = 4,
  parameter int LEN = 4,
  parameter int TW  = 5
) (
  input  logic [TW-1:0] t,
  output logic [N-1:0]  lane
);

  // Window compare per lane.
  always_comb begin
    lane = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      lane[i] = (int'(t) >= i) && (int'(t) < i + LEN);
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the DataPath systolic array: loads weights and neurons from a
// valid/ready stream, fires the skewed read wavefront, then waits for dp_done.
// Optional drain timeout: define SYSTOLIC_CTRL_TIMEOUT_EN.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ROW       = DEF_ROW,
  parameter int COL       = DEF_COL,
  parameter int DRAIN_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_in,
  output logic [ROW-1:0]   writew,
  output logic [COL-1:0]   writen,
  output logic [ROW-1:0]   readw,
  output logic [COL-1:0]   readn,
  output logic             cs,
  input  logic             dp_done,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(ROW*COL+1);
  localparam logic [CW-1:0] LAST_K  = CW'(ROW*COL-1);
  localparam logic [CW-1:0] T_LAST  = CW'(ROW+COL-2);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             accept_s;
  logic             timeout_s;
  int               lane_idx_s;
  logic [ROW-1:0]   readw_s;
  logic [COL-1:0]   readn_s;

  logic             in_ready_r;
  logic [WIDTH-1:0] data_in_r;
  logic [ROW-1:0]   writew_r;
  logic [COL-1:0]   writen_r;
  logic [ROW-1:0]   readw_r;
  logic [COL-1:0]   readn_r;
  logic             cs_r;
  logic             busy_r;
  logic             done_r;

  // in_ready is only ever high in the load states, so this is the handshake.
  assign accept_s = in_ready_r & in_valid;

  // The same counter serves as word index while loading and as the
  // wavefront step while streaming.
  skew_gen #(.N(ROW), .LEN(COL), .TW(CW)) u_skew_w (.t(cnt_s), .lane(readw_s));
  skew_gen #(.N(COL), .LEN(ROW), .TW(CW)) u_skew_n (.t(cnt_s), .lane(readn_s));

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_MAX+1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX-1);

  logic [DW-1:0] drain_r;
  logic          err_r;

  // Cycles spent in DRAIN; idle at zero in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_r <= {DW{1'b0}};
    end else if (state_r == DRAIN) begin
      drain_r <= drain_r + DW'(1);
    end else begin
      drain_r <= {DW{1'b0}};
    end
  end

  assign timeout_s = (state_r == DRAIN) && (drain_r == DRAIN_LAST) && !dp_done;

  // Sticky timeout flag, cleared only when a new job is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Row index for weights (row-major), column index for neurons (column-major).
  always_comb begin
    if (state_r == LOAD_W) begin
      lane_idx_s = int'(cnt_r) / COL;
    end else begin
      lane_idx_s = int'(cnt_r) / ROW;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD_W;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_W, LOAD_N: begin
        if (accept_s && (cnt_r == LAST_K)) begin
          state_s = (state_r == LOAD_W) ? LOAD_N : ARM;
          cnt_s   = {CW{1'b0}};
        end else if (accept_s) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ARM: begin
        state_s = STREAM;
        cnt_s   = {CW{1'b0}};
      end
      STREAM: begin
        if (cnt_r == T_LAST) begin
          state_s = DRAIN;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DRAIN: begin
        if (dp_done || timeout_s) begin
          state_s = FIN;
        end else begin
          state_s = DRAIN;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      in_ready_r <= 1'b0;
      data_in_r  <= {WIDTH{1'b0}};
      writew_r   <= {ROW{1'b0}};
      writen_r   <= {COL{1'b0}};
      readw_r    <= {ROW{1'b0}};
      readn_r    <= {COL{1'b0}};
      cs_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      in_ready_r <= (state_s == LOAD_W) || (state_s == LOAD_N);
      if (accept_s) begin
        data_in_r <= in_data;
      end else begin
        data_in_r <= data_in_r;
      end
      // Write strobe lands one cycle after acceptance, even if that is ARM.
      writew_r <= (accept_s && (state_r == LOAD_W)) ? ROW'(onehot(lane_idx_s, ROW)) : {ROW{1'b0}};
      writen_r <= (accept_s && (state_r == LOAD_N)) ? COL'(onehot(lane_idx_s, COL)) : {COL{1'b0}};
      readw_r  <= (state_s == STREAM) ? readw_s : {ROW{1'b0}};
      readn_r  <= (state_s == STREAM) ? readn_s : {COL{1'b0}};
      cs_r     <= (state_s == ARM) || (state_s == STREAM) || (state_s == DRAIN);
      busy_r   <= (state_s != IDLE);
      done_r   <= (state_s == FIN);
    end
  end

  assign in_ready = in_ready_r;
  assign data_in  = data_in_r;
  assign writew   = writew_r;
  assign writen   = writen_r;
  assign readw    = readw_r;
  assign readn    = readn_r;
  assign cs       = cs_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
